// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a registered byte ROM through the PC, assembles
// one- or two-byte instructions and hands them to execute. Optional HALT: FETCH_SEQ_HALT_EN.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en_i,
  input  logic [11:0] pc_i,
  output logic        pc_enable_o,
  output logic        pc_load_o,
  output logic [11:0] pc_target_o,
  input  logic [7:0]  rom_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [3:0]  instr_opcode_o,
  output logic [3:0]  instr_imm_o,
  output logic [11:0] instr_addr_o,
  output logic [11:0] instr_pc_o,
  input  logic        br_taken_i,
  input  logic [11:0] br_target_i,
  output logic        halted_o
);

`ifdef FETCH_SEQ_HALT_EN
  typedef enum logic [2:0] {StAddr, StByte1, StByte2, StIssue, StHalt} state_e;
`else
  typedef enum logic [1:0] {StAddr, StByte1, StByte2, StIssue} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [7:0]  byte2_q, byte2_d;
  logic [11:0] instr_pc_q, instr_pc_d;
  logic        two_byte;

  // Opcodes 0x8-0xB carry a second address byte.
  assign two_byte = (byte1_q[7:6] == 2'b10);

  always_comb begin
    state_d       = state_q;
    byte1_d       = byte1_q;
    byte2_d       = byte2_q;
    instr_pc_d    = instr_pc_q;
    pc_enable_o   = 1'b0;
    pc_load_o     = 1'b0;
    pc_target_o   = 12'h000;
    instr_valid_o = 1'b0;

    unique case (state_q)
      StAddr: begin
        if (fetch_en_i) begin
          instr_pc_d  = pc_i;
          pc_enable_o = 1'b1;
          state_d     = StByte1;
        end
      end
      StByte1: begin
        byte1_d = rom_data_i;
        if (rom_data_i[7:6] == 2'b10) begin
          pc_enable_o = 1'b1;
          state_d     = StByte2;
        end else begin
          state_d = StIssue;
        end
      end
      StByte2: begin
        byte2_d = rom_data_i;
        state_d = StIssue;
      end
      StIssue: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          state_d = StAddr;
`ifdef FETCH_SEQ_HALT_EN
          if (byte1_q == 8'hFF) begin
            state_d = StHalt;
          end else
`endif
          if (br_taken_i) begin
            pc_load_o   = 1'b1;
            pc_target_o = br_target_i;
          end
        end
      end
`ifdef FETCH_SEQ_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StAddr;
    endcase

    // Reset wins over everything, including the combinational PC requests of this cycle.
    if (reset) begin
      pc_enable_o   = 1'b0;
      pc_load_o     = 1'b0;
      pc_target_o   = 12'h000;
      instr_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAddr;
      byte1_q    <= 8'h00;
      byte2_q    <= 8'h00;
      instr_pc_q <= 12'h000;
    end else begin
      state_q    <= state_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign instr_opcode_o = byte1_q[7:4];
  assign instr_imm_o    = byte1_q[3:0];
  assign instr_addr_o   = two_byte ? {byte1_q[3:0], byte2_q} : 12'h000;
  assign instr_pc_o     = instr_pc_q;

`ifdef FETCH_SEQ_HALT_EN
  assign halted_o = (state_q == StHalt);
`else
  assign halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, randomized instruction stream against an
// instruction-level model, plus reset-in-flight and HALT sequences.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en, instr_ready, br_taken;
  logic [11:0] pc, br_target, pc_target, instr_addr, instr_pc;
  logic        pc_enable, pc_load, instr_valid, halted;
  logic [7:0]  rom_data;
  logic [3:0]  instr_opcode, instr_imm;

  logic [7:0]  rom [4096];
  logic [11:0] mpc;
  int          checks = 0;
  int          failures = 0;
  int          en_cnt = 0;
  int          ld_cnt = 0;
  bit          mon_on = 1'b0;

  typedef struct {
    logic [11:0] at;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          stall;
    int          rdly;
    bit          br;
    logic [11:0] tgt;
    logic [3:0]  op;
    logic [3:0]  imm;
    logic [11:0] addr;
    int          lat;
  } vec_t;
  vec_t tbl [9];

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en_i     (fetch_en),
    .pc_i           (pc),
    .pc_enable_o    (pc_enable),
    .pc_load_o      (pc_load),
    .pc_target_o    (pc_target),
    .rom_data_i     (rom_data),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .instr_opcode_o (instr_opcode),
    .instr_imm_o    (instr_imm),
    .instr_addr_o   (instr_addr),
    .instr_pc_o     (instr_pc),
    .br_taken_i     (br_taken),
    .br_target_i    (br_target),
    .halted_o       (halted)
  );

  always #5 clk = ~clk;

  // Program counter and registered ROM surrounding the sequencer.
  always @(posedge clk) begin
    if (reset) pc <= 12'h000;
    else if (pc_load) pc <= pc_target;
    else if (pc_enable) pc <= pc + 12'd1;
    rom_data <= rom[pc];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pc_enable) en_cnt++;
    if (pc_load) ld_cnt++;
    if (mon_on) chk("pc_excl", 32'(pc_enable & pc_load), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of a cycle with the DUT idle in the address state.
  task automatic run_instr(input int stall, input int rdly, input bit br, input logic [11:0] tgt,
                           input logic [3:0] e_op, input logic [3:0] e_imm,
                           input logic [11:0] e_addr, input int e_lat, input logic [11:0] e_pc);
    int lat;
    instr_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      fetch_en  = 1'b0;
      br_taken  = 1'($urandom);
      br_target = 12'($urandom);
      #1;
      chk("stall_en", 32'(pc_enable), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    fetch_en = 1'b1;
    br_taken = 1'($urandom);
    en_cnt   = 0;
    ld_cnt   = 0;
    #1;
    chk("addr_valid", 32'(instr_valid), 32'd0);
    lat = 0;
    do begin
      tick();
      lat++;
      fetch_en = 1'($urandom);
      if (rdly == 0) begin
        instr_ready = 1'b1;
        br_taken    = br;
        br_target   = tgt;
      end else begin
        instr_ready = 1'b0;
        br_taken    = 1'($urandom);
        br_target   = 12'($urandom);
      end
      #1;
    end while (!instr_valid && lat < 8);
    chk("valid", 32'(instr_valid), 32'd1);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("opcode", 32'(instr_opcode), 32'(e_op));
    chk("imm", 32'(instr_imm), 32'(e_imm));
    chk("addr", 32'(instr_addr), 32'(e_addr));
    chk("instr_pc", 32'(instr_pc), 32'(e_pc));
    chk("en_pulses", 32'(en_cnt), 32'(e_lat - 1));
    chk("ld_pulses", 32'(ld_cnt), 32'd0);
    if (rdly > 0) begin
      for (int i = 0; i < rdly; i++) begin
        if (i > 0) begin
          tick();
          br_taken  = 1'($urandom);
          br_target = 12'($urandom);
          #1;
        end
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_fields", {8'h00, instr_opcode, instr_imm, instr_addr},
            {8'h00, e_op, e_imm, e_addr});
        chk("hold_pc", 32'(instr_pc), 32'(e_pc));
        chk("hold_req", 32'({pc_enable, pc_load}), 32'd0);
      end
      tick();
      instr_ready = 1'b1;
      br_taken    = br;
      br_target   = tgt;
      #1;
    end
    chk("acc_valid", 32'(instr_valid), 32'd1);
    chk("acc_load", 32'(pc_load), 32'(br));
    chk("acc_target", 32'(pc_target), br ? 32'(tgt) : 32'd0);
    chk("acc_en", 32'(pc_enable), 32'd0);
    tick();
    instr_ready = 1'b0;
    br_taken    = 1'b0;
  endtask

  // Expectations derived from ROM contents at the model's notion of the next fetch address.
  task automatic run_model(input int stall, input int rdly, input bit br, input logic [11:0] tgt);
    logic [7:0]  b1, b2;
    logic [11:0] a1;
    bit          two;
    a1  = mpc + 12'd1;
    b1  = rom[mpc];
    b2  = rom[a1];
    two = (b1 >= 8'h80) && (b1 <= 8'hBF);
    run_instr(stall, rdly, br, tgt, b1[7:4], b1[3:0], two ? {b1[3:0], b2} : 12'h000,
              two ? 3 : 2, mpc);
    mpc = br ? tgt : mpc + (two ? 12'd2 : 12'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a1;
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
`ifdef FETCH_SEQ_HALT_EN
      if (rom[i] == 8'hFF) rom[i] = 8'hFE;
`endif
    end
    tbl[0] = '{12'h000, 8'h3A, 8'h00, 0, 0, 1'b1, 12'h010, 4'h3, 4'hA, 12'h000, 2};
    tbl[1] = '{12'h010, 8'h92, 8'h45, 1, 2, 1'b0, 12'h000, 4'h9, 4'h2, 12'h245, 3};
    tbl[2] = '{12'h012, 8'h5C, 8'h00, 0, 0, 1'b1, 12'h7F0, 4'h5, 4'hC, 12'h000, 2};
    tbl[3] = '{12'h7F0, 8'hB1, 8'h23, 0, 1, 1'b1, 12'hFFF, 4'hB, 4'h1, 12'h123, 3};
    tbl[4] = '{12'hFFF, 8'hA7, 8'h12, 0, 0, 1'b0, 12'h000, 4'hA, 4'h7, 12'h712, 3};
    tbl[5] = '{12'h001, 8'h00, 8'h00, 3, 5, 1'b0, 12'h000, 4'h0, 4'h0, 12'h000, 2};
    tbl[6] = '{12'h002, 8'h8F, 8'hE0, 0, 0, 1'b0, 12'h000, 4'h8, 4'hF, 12'hFE0, 3};
    tbl[7] = '{12'h004, 8'hC0, 8'h00, 0, 0, 1'b0, 12'h000, 4'hC, 4'h0, 12'h000, 2};
    tbl[8] = '{12'h005, 8'h7F, 8'h00, 0, 0, 1'b0, 12'h000, 4'h7, 4'hF, 12'h000, 2};

    // Reset overrides active inputs and clears the captured instruction.
    reset = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1; br_taken = 1'b1; br_target = 12'h555;
    tick();
    tick();
    #1;
    chk("rst_req", 32'({pc_enable, pc_load}), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_target", 32'(pc_target), 32'd0);
    chk("rst_fields", {8'h00, instr_opcode, instr_imm, instr_addr}, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; br_taken = 1'b0;
    mon_on = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      a1 = tbl[i].at + 12'd1;
      rom[tbl[i].at] = tbl[i].b1;
      rom[a1]        = tbl[i].b2;
      run_instr(tbl[i].stall, tbl[i].rdly, tbl[i].br, tbl[i].tgt, tbl[i].op, tbl[i].imm,
                tbl[i].addr, tbl[i].lat, tbl[i].at);
      mpc = tbl[i].br ? tbl[i].tgt : tbl[i].at + 12'(tbl[i].lat - 1);
    end

    for (int n = 0; n < 150; n++) begin
      run_model($urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom));
    end

    // Reset while waiting for the second byte: nothing issues, fetch restarts at 0x000.
    a1 = mpc + 12'd1;
    rom[mpc] = 8'hA5;
    rom[a1]  = 8'h66;
    fetch_en = 1'b1;
    en_cnt   = 0;
    ld_cnt   = 0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rstb2_req", 32'({pc_enable, pc_load}), 32'd0);
    chk("rstb2_valid", 32'(instr_valid), 32'd0);
    tick();
    reset    = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("rstb2_after_valid", 32'(instr_valid), 32'd0);
    chk("rstb2_after_pc", 32'(instr_pc), 32'd0);
    chk("rstb2_after_fields", {8'h00, instr_opcode, instr_imm, instr_addr}, 32'd0);
    chk("rstb2_en_pulses", 32'(en_cnt), 32'd2);
    tick();
    mpc = 12'h000;
    run_model(0, 0, 1'b0, 12'h000);
    run_model(1, 1, 1'b0, 12'h000);

`ifdef FETCH_SEQ_HALT_EN
    rom[mpc] = 8'hFF;
    run_model(0, 1, 1'b0, 12'h000);
    en_cnt = 0;
    ld_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      br_taken    = 1'($urandom);
      #1;
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    chk("halt_en_pulses", 32'(en_cnt), 32'd0);
    chk("halt_ld_pulses", 32'(ld_cnt), 32'd0);
    reset = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; br_taken = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("halt_cleared", 32'(halted), 32'd0);
    tick();
    mpc = 12'h000;
    run_model(0, 0, 1'b0, 12'h000);
`else
    rom[mpc] = 8'hFF;
    run_model(0, 0, 1'b0, 12'h000);
    #1;
    chk("no_halt", 32'(halted), 32'd0);
    run_model(0, 0, 1'b0, 12'h000);
    run_model(0, 2, 1'b0, 12'h000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: none; widths fixed at 12-bit address, 8-bit instruction byte, 4-bit opcode/immediate.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_en  input  1  1 = fetching permitted; 0 = sequencer stalls in S_ADDR.
REQ-005 pc  input  12  current program-counter value; also drives program ROM address.
REQ-006 pc_enable  output  1  one-cycle increment request to program counter.
REQ-007 pc_load  output  1  one-cycle load request to program counter.
REQ-008 pc_target  output  12  load value; valid when pc_load=1, else 0.
REQ-009 rom_data  input  8  ROM byte; registered ROM, rom_data at cycle t+1 = ROM[pc at cycle t].
REQ-010 instr_valid  output  1  assembled instruction available.
REQ-011 instr_ready  input  1  execute stage accepts instruction.
REQ-012 instr_opcode / instr_imm  output  4 / 4  first byte [7:4] / [3:0].
REQ-013 instr_addr  output  12  {instr_imm, second byte} for two-byte instructions, else 0.
REQ-014 instr_pc  output  12  address of the instruction's first byte.
REQ-015 br_taken / br_target  input  1 / 12  redirect request from execute stage.
REQ-016 halted  output  1  sequencer stopped on HALT (see Configuration).

Function
REQ-017 FSM states SHALL be S_ADDR, S_BYTE1, S_BYTE2, S_ISSUE (plus S_HALT when configured).
REQ-018 S_ADDR: if fetch_en=1 -> latch pc into instr_pc, pc_enable=1, go S_BYTE1; else hold, no pc_enable.
REQ-019 S_BYTE1: latch rom_data as first byte; opcode[3:2]=2'b10 (0x8-0xB) -> two-byte: pc_enable=1, go S_BYTE2; otherwise go S_ISSUE.
REQ-020 S_BYTE2: latch rom_data as second byte; go S_ISSUE.
REQ-021 S_ISSUE: instr_valid=1; all instr_* outputs held stable until instr_valid&&instr_ready.
REQ-022 On accept with br_taken=0 -> go S_ADDR, no PC request.
REQ-023 On accept with br_taken=1 -> pc_load=1, pc_target=br_target same cycle, go S_ADDR.
REQ-024 br_taken SHALL be ignored in every cycle without instr_valid&&instr_ready.
REQ-025 pc_enable and pc_load SHALL never be asserted in the same cycle; each is a single-cycle pulse.
REQ-026 Latency S_ADDR to instr_valid: 2 cycles one-byte, 3 cycles two-byte; back-to-back one-byte throughput 1 instruction / 3 cycles.
REQ-027 Address wrap: fetch at 0xFFF continues at 0x000 (counter wraps); two-byte instruction at 0xFFF takes its second byte from 0x000, instr_pc=0xFFF.
REQ-028 fetch_en deasserted mid-instruction SHALL NOT abort it; stall only takes effect in S_ADDR.

Reset
REQ-029 reset=1 at clock edge -> state S_ADDR, all outputs 0, captured bytes/instr_pc cleared; overrides every other input.
REQ-030 reset mid-instruction SHALL discard partial instruction with no pc_enable/pc_load in the reset cycle; counter is reset by the same system reset.

Configuration
REQ-031 Macro FETCH_SEQ_HALT_EN defined: byte 0xFF is HALT; on its accept sequencer enters S_HALT, halted=1, no further PC requests or instr_valid until reset.
REQ-032 FETCH_SEQ_HALT_EN undefined: 0xFF is an ordinary one-byte instruction, S_HALT absent, halted tied 0.

Verification
REQ-033 ROM[0x000]=0x3A, instr_ready=1 -> instr_valid cycle 3 after reset release, opcode=0x3, imm=0xA, instr_pc=0x000, exactly one pc_enable.
REQ-034 ROM[0x010]=0x92, ROM[0x011]=0x45 -> instr_opcode=0x9, instr_addr=0x245, two pc_enable pulses, instr_valid 3 cycles after S_ADDR.
REQ-035 instr_ready held 0 for 5 cycles at S_ISSUE -> outputs stable, no PC requests; accept on cycle 6 -> next fetch from pc+1.
REQ-036 Accept with br_taken=1, br_target=0x7F0 -> single pc_load pulse, pc_target=0x7F0, next instr_pc=0x7F0.
REQ-037 Two-byte opcode 0xA at 0xFFF, ROM[0x000]=0x12 -> instr_addr={imm,0x12}, instr_pc=0xFFF; reset asserted in S_BYTE2 -> no instr_valid, restart at 0x000.
REQ-038 With FETCH_SEQ_HALT_EN, 0xFF accepted -> halted=1, zero PC requests for 20 cycles; without macro -> normal fetch continues.
